// File: rtl/stream_wrr_pkt_arbiter_pkg.sv
// rtl/stream_wrr_pkt_arbiter_pkg.sv - shared constants and helpers for the packet WRR arbiter
// Purpose: FSM state encodings and the index-width helper used by the arbiter and its lzc.
// Ports: none (package).
package stream_wrr_pkt_arbiter_pkg;

  // Grant FSM: IDLE re-arbitrates every cycle, LOCK holds the grant until the packet ends.
  localparam logic STATE_IDLE = 1'b0;
  localparam logic STATE_LOCK = 1'b1;

  // Width of an index into n entries; a single entry still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_wrr_pkt_arbiter_lzc.sv
// rtl/stream_wrr_pkt_arbiter_lzc.sv - trailing-zero counter (position of first set bit from LSB)
// Purpose: finds the first requester in the priority-rotated valid vector.
// Ports:
//   in_i     in   WIDTH                 request vector, bit 0 has highest priority
//   cnt_o    out  idx_width(WIDTH)      index of lowest set bit, 0 when empty
//   empty_o  out  1                     no bit set
module stream_wrr_pkt_arbiter_lzc
  import stream_wrr_pkt_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 2,
  localparam int unsigned CNT_W = idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0] in_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             empty_o
);

  // Scan from the top so the lowest set bit is the last to overwrite.
  always_comb begin
    cnt_o = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (in_i[i]) cnt_o = CNT_W'(i);
    end
  end

  assign empty_o = ~|in_i;

endmodule

// File: rtl/stream_wrr_pkt_arbiter.sv
// rtl/stream_wrr_pkt_arbiter.sv - packet-aware weighted round-robin stream arbiter
// Purpose: multiplexes N_INP valid/ready streams onto one output, holding the grant for a
//   whole packet and for up to weight+1 consecutive packets per input. Zero-latency data path.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   inp_weight_i    per-input weight (WEIGHT_W bits each), sampled at packet end
//   inp_data_i      per-input payload
//   inp_last_i      per-input last-beat flag
//   inp_valid_i     per-input valid
//   inp_ready_o     per-input ready, one-hot at the selected input
//   oup_data_o      selected payload
//   oup_last_o      selected last flag
//   oup_valid_o     selected valid
//   oup_ready_i     downstream ready
//   oup_idx_o       index of the selected input
module stream_wrr_pkt_arbiter
  import stream_wrr_pkt_arbiter_pkg::*;
#(
  parameter type         DATA_T   = logic,
  parameter int unsigned N_INP    = 2,
  parameter int unsigned WEIGHT_W = 4,
  localparam int unsigned IDX_W   = idx_width(N_INP)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [N_INP*WEIGHT_W-1:0] inp_weight_i,
  input  DATA_T [N_INP-1:0]         inp_data_i,
  input  logic [N_INP-1:0]          inp_last_i,
  input  logic [N_INP-1:0]          inp_valid_i,
  output logic [N_INP-1:0]          inp_ready_o,
  output DATA_T                     oup_data_o,
  output logic                      oup_last_o,
  output logic                      oup_valid_o,
  input  logic                      oup_ready_i,
  output logic [IDX_W-1:0]          oup_idx_o
);

  if (N_INP == 0) begin : g_bad_n_inp
    $fatal(1, "stream_wrr_pkt_arbiter: N_INP must be at least 1");
  end

  logic                state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    sel_q, sel_d;
  logic [WEIGHT_W-1:0] cnt_q, cnt_d;

  logic [N_INP-1:0]    valid_rot;
  logic [IDX_W-1:0]    lzc_cnt;
  logic                lzc_empty;
  logic [IDX_W-1:0]    sel_idle;
  logic [IDX_W-1:0]    sel;
  logic                any_req;
  logic                hs;
  logic                pkt_end;
  logic [WEIGHT_W-1:0] sel_weight;
  logic [WEIGHT_W-1:0] eff_cnt;

  // (a + b) mod N_INP for operands already below N_INP.
  function automatic logic [IDX_W-1:0] add_mod(input logic [IDX_W-1:0] a,
                                               input logic [IDX_W-1:0] b);
    logic [IDX_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= (IDX_W+1)'(N_INP)) s = s - (IDX_W+1)'(N_INP);
    return s[IDX_W-1:0];
  endfunction

  // Rotate so that bit 0 is the input at the priority head.
  always_comb begin
    valid_rot = '0;
    for (int unsigned i = 0; i < N_INP; i++) begin
      valid_rot[i] = inp_valid_i[add_mod(ptr_q, IDX_W'(i))];
    end
  end

  stream_wrr_pkt_arbiter_lzc #(
    .WIDTH (N_INP)
  ) u_lzc (
    .in_i    (valid_rot),
    .cnt_o   (lzc_cnt),
    .empty_o (lzc_empty)
  );

  assign sel_idle = add_mod(ptr_q, lzc_cnt);
  assign sel      = (state_q == STATE_LOCK) ? sel_q : sel_idle;

  // A held grant keeps ready on its input through valid gaps; in IDLE nobody is ready
  // unless someone is actually requesting.
  assign any_req = (state_q == STATE_LOCK) | ~lzc_empty;

  assign oup_data_o  = inp_data_i[sel];
  assign oup_last_o  = inp_last_i[sel];
  assign oup_valid_o = inp_valid_i[sel];
  assign oup_idx_o   = sel;

  always_comb begin
    inp_ready_o = '0;
    for (int unsigned i = 0; i < N_INP; i++) begin
      inp_ready_o[i] = oup_ready_i & any_req & (sel == IDX_W'(i));
    end
  end

  assign hs      = oup_valid_o & oup_ready_i;
  assign pkt_end = hs & oup_last_o;

  always_comb begin
    sel_weight = '0;
    for (int unsigned i = 0; i < N_INP; i++) begin
      if (sel == IDX_W'(i)) sel_weight = inp_weight_i[i*WEIGHT_W +: WEIGHT_W];
    end
  end

  // A packet from an input other than the head starts a fresh turn for that input.
  assign eff_cnt = (sel == ptr_q) ? cnt_q : '0;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;

    if (state_q == STATE_IDLE) begin
      sel_d = sel;
      // Lock on a stall too, so the presented beat cannot be re-arbitrated away.
      if (oup_valid_o && (!oup_ready_i || !oup_last_o)) state_d = STATE_LOCK;
    end else if (pkt_end) begin
      state_d = STATE_IDLE;
    end

    if (pkt_end) begin
      // >= so that a weight lowered mid-turn still closes the turn.
      if (eff_cnt >= sel_weight) begin
        ptr_d = add_mod(sel, IDX_W'(1));
        cnt_d = '0;
      end else begin
        ptr_d = sel;
        cnt_d = eff_cnt + WEIGHT_W'(1);
      end
    end

    if (N_INP == 1) begin
      ptr_d = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= STATE_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
    end
  end

  // Sources may not retract or alter a beat that is waiting for ready.
  for (genvar gi = 0; gi < N_INP; gi++) begin : g_proto
    a_hold_beat : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (inp_valid_i[gi] && !inp_ready_o[gi]) |=>
        (inp_valid_i[gi] && $stable(inp_data_i[gi]) && $stable(inp_last_i[gi])));
  end

endmodule

// File: tb/tb_stream_wrr_pkt_arbiter.sv
// tb/tb_stream_wrr_pkt_arbiter.sv - self-checking bench for stream_wrr_pkt_arbiter
module tb_stream_wrr_pkt_arbiter;

  logic             clk;
  logic             rst_n;
  logic [5:0]       weight;
  logic [2:0][7:0]  in_data;
  logic [2:0]       in_last;
  logic [2:0]       in_valid;
  logic [2:0]       in_ready;
  logic [7:0]       o_data;
  logic             o_last;
  logic             o_valid;
  logic             o_ready;
  logic [1:0]       o_idx;

  logic [1:0]       s_weight;
  logic [0:0][7:0]  s_data;
  logic [0:0]       s_last;
  logic [0:0]       s_valid;
  logic [0:0]       s_ready;
  logic [7:0]       s_odata;
  logic             s_olast;
  logic             s_ovalid;
  logic             s_oready;
  logic [0:0]       s_idx;

  int n_cmp = 0;
  int n_bad = 0;

  stream_wrr_pkt_arbiter #(
    .DATA_T   (logic [7:0]),
    .N_INP    (3),
    .WEIGHT_W (2)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .inp_weight_i (weight),
    .inp_data_i   (in_data),
    .inp_last_i   (in_last),
    .inp_valid_i  (in_valid),
    .inp_ready_o  (in_ready),
    .oup_data_o   (o_data),
    .oup_last_o   (o_last),
    .oup_valid_o  (o_valid),
    .oup_ready_i  (o_ready),
    .oup_idx_o    (o_idx)
  );

  stream_wrr_pkt_arbiter #(
    .DATA_T   (logic [7:0]),
    .N_INP    (1),
    .WEIGHT_W (2)
  ) dut1 (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .inp_weight_i (s_weight),
    .inp_data_i   (s_data),
    .inp_last_i   (s_last),
    .inp_valid_i  (s_valid),
    .inp_ready_o  (s_ready),
    .oup_data_o   (s_odata),
    .oup_last_o   (s_olast),
    .oup_valid_o  (s_ovalid),
    .oup_ready_i  (s_oready),
    .oup_idx_o    (s_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_before;
    logic [5:0] weight;
    logic [2:0] valid;
    logic       ready;
    logic       exp_valid;
    logic [1:0] exp_idx;
    logic [2:0] exp_ready;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rb, input logic [5:0] w, input logic [2:0] v,
                              input logic r, input logic ev, input logic [1:0] ei,
                              input logic [2:0] er);
    vec_t t;
    t.rst_before = rb; t.weight = w; t.valid = v; t.ready = r;
    t.exp_valid = ev; t.exp_idx = ei; t.exp_ready = er;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic ev, input logic [1:0] ei,
                            input logic [2:0] er, input logic [7:0] ed);
    check({tag, ".valid"}, 32'(o_valid), 32'(ev));
    check({tag, ".idx"},   32'(o_idx),   32'(ei));
    check({tag, ".ready"}, 32'(in_ready), 32'(er));
    if (ev) check({tag, ".data"}, 32'(o_data), 32'(ed));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 3'b000;
    s_valid  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  localparam logic [5:0] W_ZERO = 6'b00_00_00;
  localparam logic [5:0] W_201  = 6'b01_00_10;
  localparam logic [5:0] W_101  = 6'b01_00_01;
  localparam logic [5:0] W_010  = 6'b00_01_00;

  initial begin
    logic [1:0] seq2 [12];
    string tag;

    rst_n    = 1'b0;
    weight   = W_ZERO;
    in_data  = {8'hC2, 8'hB1, 8'hA0};
    in_last  = 3'b111;
    in_valid = 3'b000;
    o_ready  = 1'b1;
    s_weight = 2'd0;
    s_data   = '0;
    s_last   = 1'b0;
    s_valid  = 1'b0;
    s_oready = 1'b0;

    // Reset state, then equal weights: plain round robin 0,1,2,...
    vecs.push_back(mk(1'b1, W_ZERO, 3'b000, 1'b1, 1'b0, 2'd0, 3'b000));
    for (int i = 0; i < 6; i++) begin
      vecs.push_back(mk(1'b0, W_ZERO, 3'b111, 1'b1, 1'b1, 2'(i % 3), 3'(1 << (i % 3))));
    end
    // Weights {2,0,1}: 0 x3, 1 x1, 2 x2 per round, wrapping back to 0.
    seq2 = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd2};
    for (int i = 0; i < 12; i++) begin
      vecs.push_back(mk(i == 0, W_201, 3'b111, 1'b1, 1'b1, seq2[i], 3'(1 << seq2[i])));
    end
    // Two packets into in0's turn, then its weight drops to 1: turn closes at once.
    vecs.push_back(mk(1'b0, W_201, 3'b111, 1'b1, 1'b1, 2'd0, 3'b001));
    vecs.push_back(mk(1'b0, W_201, 3'b111, 1'b1, 1'b1, 2'd0, 3'b001));
    vecs.push_back(mk(1'b0, W_101, 3'b111, 1'b1, 1'b1, 2'd0, 3'b001));
    vecs.push_back(mk(1'b0, W_101, 3'b111, 1'b1, 1'b1, 2'd1, 3'b010));

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst_before) do_reset();
      @(negedge clk);
      weight   = vecs[i].weight;
      in_valid = vecs[i].valid;
      o_ready  = vecs[i].ready;
      #1;
      tag = $sformatf("vec%0d", i);
      expect_out(tag, vecs[i].exp_valid, vecs[i].exp_idx, vecs[i].exp_ready,
                 8'hA0 + 8'h11 * 8'(vecs[i].exp_idx));
    end

    // Multi-beat packet on in0 with a valid gap; in1 waits for the last beat.
    do_reset();
    weight  = W_ZERO;
    in_last = 3'b111;
    @(negedge clk); in_valid = 3'b011; in_data[0] = 8'h01; in_last[0] = 1'b0; #1;
    expect_out("pkt.b1", 1'b1, 2'd0, 3'b001, 8'h01);
    @(negedge clk); in_data[0] = 8'h02; #1;
    expect_out("pkt.b2", 1'b1, 2'd0, 3'b001, 8'h02);
    for (int g = 0; g < 2; g++) begin
      @(negedge clk); in_valid[0] = 1'b0; #1;
      expect_out("pkt.gap", 1'b0, 2'd0, 3'b001, 8'h00);
    end
    @(negedge clk); in_valid[0] = 1'b1; in_data[0] = 8'h03; #1;
    expect_out("pkt.b3", 1'b1, 2'd0, 3'b001, 8'h03);
    @(negedge clk); in_data[0] = 8'h04; in_last[0] = 1'b1; #1;
    expect_out("pkt.b4", 1'b1, 2'd0, 3'b001, 8'h04);
    @(negedge clk); in_valid[0] = 1'b0; #1;
    expect_out("pkt.next", 1'b1, 2'd1, 3'b010, 8'hB1);

    // Stall on in2; a late request from in0 must not disturb the presented beat.
    @(negedge clk); in_valid = 3'b100; in_data[0] = 8'hA0; o_ready = 1'b0; #1;
    expect_out("stall.a", 1'b1, 2'd2, 3'b000, 8'hC2);
    @(negedge clk); in_valid = 3'b101; #1;
    expect_out("stall.b", 1'b1, 2'd2, 3'b000, 8'hC2);
    check("stall.last", 32'(o_last), 32'd1);
    @(negedge clk); o_ready = 1'b1; #1;
    expect_out("stall.hs", 1'b1, 2'd2, 3'b100, 8'hC2);
    @(negedge clk); in_valid = 3'b001; #1;
    expect_out("stall.after", 1'b1, 2'd0, 3'b001, 8'hA0);

    // Reset while locked mid-packet on in1 with ptr=1, cnt=1.
    do_reset();
    weight = W_010;
    @(negedge clk); in_valid = 3'b011; in_last = 3'b111; #1;
    expect_out("rst.p0", 1'b1, 2'd0, 3'b001, 8'hA0);
    @(negedge clk); in_valid = 3'b010; #1;
    expect_out("rst.p1", 1'b1, 2'd1, 3'b010, 8'hB1);
    @(negedge clk); in_last[1] = 1'b0; #1;
    expect_out("rst.lock", 1'b1, 2'd1, 3'b010, 8'hB1);
    @(negedge clk); rst_n = 1'b0; in_valid = 3'b110; in_last = 3'b111; #1;
    check("rst.ptr", 32'(dut.ptr_q), 32'd0);
    check("rst.cnt", 32'(dut.cnt_q), 32'd0);
    expect_out("rst.during", 1'b1, 2'd1, 3'b010, 8'hB1);
    @(negedge clk); rst_n = 1'b1; #1;
    expect_out("rst.q1", 1'b1, 2'd1, 3'b010, 8'hB1);
    @(negedge clk); #1;
    expect_out("rst.q2", 1'b1, 2'd1, 3'b010, 8'hB1);
    @(negedge clk); #1;
    expect_out("rst.q3", 1'b1, 2'd2, 3'b100, 8'hC2);

    // Single-input pass-through with random traffic.
    do_reset();
    in_valid = 3'b000;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (!(s_valid[0] && !s_oready)) begin
        s_valid[0] = 1'($urandom_range(0, 1));
        s_last[0]  = 1'($urandom_range(0, 1));
        s_data[0]  = 8'($urandom_range(0, 255));
      end
      s_oready = 1'($urandom_range(0, 1));
      #1;
      check("p1.data",  32'(s_odata),  32'(s_data[0]));
      check("p1.last",  32'(s_olast),  32'(s_last[0]));
      check("p1.valid", 32'(s_ovalid), 32'(s_valid[0]));
      check("p1.idx",   32'(s_idx),    32'd0);
      if (s_valid[0]) check("p1.ready", 32'(s_ready[0]), 32'(s_oready));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
